// File: rtl/taghreed_2to4_decoder.sv
// 2-to-4 line decoder in a TinyTapeout tile wrapper.
// Registered one-hot output with enable, polarity and status echo bits.
module taghreed_2to4_decoder #(
    parameter bit REGISTER_OUT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [1:0] sel_d;
    logic       en_d;
    logic       inv_d;
    logic [3:0] raw_d;

    logic [1:0] sel_o;
    logic       en_o;
    logic       inv_o;
    logic [3:0] raw_o;

    logic [2:0] ones;
    logic       err;
    logic       unused_ok;

    assign sel_d = ui_in[1:0];
    assign en_d  = ui_in[2];
    assign inv_d = ui_in[3];

    always_comb begin
        raw_d = 4'b0000;
        if (en_d) begin
            raw_d = 4'b0001 << sel_d;
        end
    end

    generate
        if (REGISTER_OUT) begin : g_reg
            logic [1:0] sel_q;
            logic       en_q;
            logic       inv_q;
            logic [3:0] raw_q;

            // inv_q clears with the rest so the whole byte reads 0 in reset
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sel_q <= 2'b00;
                    en_q  <= 1'b0;
                    inv_q <= 1'b0;
                    raw_q <= 4'b0000;
                end else if (ena) begin
                    sel_q <= sel_d;
                    en_q  <= en_d;
                    inv_q <= inv_d;
                    raw_q <= raw_d;
                end
            end

            assign sel_o = sel_q;
            assign en_o  = en_q;
            assign inv_o = inv_q;
            assign raw_o = raw_q;
        end else begin : g_comb
            assign sel_o = sel_d;
            assign en_o  = en_d;
            assign inv_o = inv_d;
            assign raw_o = raw_d;
        end
    endgenerate

    // self-check: raw must be one-hot when enabled, empty otherwise
    assign ones = {2'b00, raw_o[0]} + {2'b00, raw_o[1]}
                + {2'b00, raw_o[2]} + {2'b00, raw_o[3]};
    assign err  = (ones != {2'b00, en_o});

    assign uo_out  = {err, en_o, sel_o, (inv_o ? ~raw_o : raw_o)};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    assign unused_ok = &{1'b0, ui_in[7:4], uio_in, clk, rst_n, ena};

endmodule

// File: tb/tb_taghreed_2to4_decoder.sv
// Self-checking bench for taghreed_2to4_decoder.
// Directed scenarios plus randomized stimulus against an arithmetic model.
`timescale 1ns/1ps
module tb_taghreed_2to4_decoder;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks;
    int n_fail;

    taghreed_2to4_decoder #(.REGISTER_OUT(1'b1)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected uo_out for a sampled ui_in, built from the decode rules
    function automatic logic [7:0] model(input logic [7:0] ui);
        int sel;
        int en;
        int inv;
        int y;
        sel = int'(ui) % 4;
        en  = (int'(ui) / 4) % 2;
        inv = (int'(ui) / 8) % 2;
        y   = (en == 1) ? (2 ** sel) : 0;
        if (inv == 1) y = 15 - y;
        return 8'(y + 16 * sel + 64 * en);
    endfunction

    task automatic drive(input logic [7:0] ui, input logic e);
        @(negedge clk);
        ui_in  = ui;
        ena    = e;
        uio_in = 8'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ui_in = 8'h07;
        ena   = 1'b1;
        rst_n = 1'b0;
        repeat (5) begin
            @(negedge clk);
            n_checks++;
            if (uo_out !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_uo_out got %h want 00", uo_out);
            end
            n_checks++;
            if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_uio got %h/%h want 00/00", uio_out, uio_oe);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sweep();
        logic [7:0] ui;
        for (int s = 0; s < 4; s++) begin
            ui = 8'h04 | 8'(s);
            drive(ui, 1'b1);
            n_checks++;
            if (uo_out !== model(ui)) begin
                n_fail++;
                $display("FAIL sweep_sel%0d got %h want %h", s, uo_out, model(ui));
            end
        end
        drive(8'h06, 1'b1);
        n_checks++;
        if (uo_out !== 8'h64) begin
            n_fail++;
            $display("FAIL sweep_sel2_literal got %h want 64", uo_out);
        end
    endtask

    task automatic test_disable();
        logic [7:0] ui;
        for (int s = 0; s < 4; s++) begin
            ui = 8'(s);
            drive(ui, 1'b1);
            n_checks++;
            if (uo_out[3:0] !== 4'b0000 || uo_out[6] !== 1'b0) begin
                n_fail++;
                $display("FAIL disable_sel%0d got %h want %h", s, uo_out, model(ui));
            end
            ui = 8'h08 | 8'(s);
            drive(ui, 1'b1);
            n_checks++;
            if (uo_out[3:0] !== 4'b1111 || uo_out !== model(ui)) begin
                n_fail++;
                $display("FAIL disable_inv_sel%0d got %h want %h", s, uo_out, model(ui));
            end
        end
    endtask

    task automatic test_invert();
        drive(8'h0D, 1'b1);
        n_checks++;
        if (uo_out[3:0] !== 4'b1101 || uo_out !== model(8'h0D)) begin
            n_fail++;
            $display("FAIL invert_sel1 got %h want %h", uo_out, model(8'h0D));
        end
        drive(8'h0F, 1'b1);
        n_checks++;
        if (uo_out[3:0] !== 4'b0111 || uo_out !== model(8'h0F)) begin
            n_fail++;
            $display("FAIL invert_sel3 got %h want %h", uo_out, model(8'h0F));
        end
    endtask

    task automatic test_hold();
        drive(8'h07, 1'b1);
        n_checks++;
        if (uo_out !== 8'h78) begin
            n_fail++;
            $display("FAIL hold_load got %h want 78", uo_out);
        end
        for (int i = 0; i < 3; i++) begin
            drive(8'h04, 1'b0);
            n_checks++;
            if (uo_out !== 8'h78) begin
                n_fail++;
                $display("FAIL hold_frozen%0d got %h want 78", i, uo_out);
            end
        end
        drive(8'h04, 1'b1);
        n_checks++;
        if (uo_out !== 8'h41) begin
            n_fail++;
            $display("FAIL hold_resume got %h want 41", uo_out);
        end
    endtask

    task automatic test_async_reset();
        drive(8'h07, 1'b1);
        n_checks++;
        if (uo_out !== 8'h78) begin
            n_fail++;
            $display("FAIL areset_pre got %h want 78", uo_out);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (uo_out !== 8'h00) begin
            n_fail++;
            $display("FAIL areset_clear got %h want 00", uo_out);
        end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (uo_out !== 8'h78) begin
            n_fail++;
            $display("FAIL areset_reload got %h want 78", uo_out);
        end
    endtask

    task automatic test_random();
        logic [7:0] expected;
        logic [7:0] ui;
        logic       e;
        expected = uo_out;
        for (int i = 0; i < 200; i++) begin
            ui = 8'($urandom);
            e  = ($urandom_range(0, 3) != 0);
            drive(ui, e);
            if (e) expected = model(ui);
            n_checks++;
            if (uo_out !== expected) begin
                n_fail++;
                $display("FAIL random_%0d ui=%h ena=%b got %h want %h",
                         i, ui, e, uo_out, expected);
            end
            n_checks++;
            if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
                n_fail++;
                $display("FAIL random_uio_%0d got %h/%h want 00/00", i, uio_out, uio_oe);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ui;
        for (int i = 0; i < 8; i++) begin
            ui = 8'h04 | 8'(i % 4) | 8'((i / 4) * 8);
            drive(ui, 1'b1);
            n_checks++;
            if (uo_out !== model(ui)) begin
                n_fail++;
                $display("FAIL b2b_%0d got %h want %h", i, uo_out, model(ui));
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        ena      = 1'b0;
        ui_in    = 8'h07;
        uio_in   = 8'h00;
        test_reset();
        test_sweep();
        test_disable();
        test_invert();
        test_hold();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
